// File: rtl/gray_to_excess3_seq_ctrl_if.sv
// Handshake bundle for the Gray -> Excess-3 sequencer.
//   in_valid / in_ready / gray         : operand side
//   out_valid / out_ready / ex3 / overflow : result side
// The master modport is the environment (producer + consumer); the slave
// modport is the converter itself.
interface gray_to_excess3_seq_ctrl_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      gray;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIGITS*4-1:0]   ex3;
  logic                  overflow;

  modport master (
    output in_valid, gray, out_ready,
    input  in_ready, out_valid, ex3, overflow
  );

  modport slave (
    input  in_valid, gray, out_ready,
    output in_ready, out_valid, ex3, overflow
  );
endinterface

// File: rtl/gray_to_excess3_seq_ctrl.sv
// Multi-cycle Gray -> binary -> BCD -> Excess-3 converter.
// One binary bit is resolved per cycle (MSB first) and shifted into a
// double-dabble BCD engine; a final cycle adds 3 to every digit.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   handshake bundle (slave side): in_valid/in_ready/gray,
//         out_valid/out_ready/ex3/overflow
//   busy  high while converting (CONV or ADJ)
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// CONV  | resolving one binary bit per cycle into the BCD engine
// ADJ   | adding 3 to each digit, registering ex3
// DONE  | result held until out_ready
module gray_to_excess3_seq_ctrl #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  gray_to_excess3_seq_ctrl_if.slave bus,
  output logic                   busy
);

  localparam int BW = DIGITS * 4;
  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {IDLE, CONV, ADJ, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BIN_W-1:0]  gray_sr;
  logic              prev_bit;
  logic [CW-1:0]     count;
  logic [BW-1:0]     bcd;
  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     ex3_nxt;
  logic              bin_bit;
  logic              accept;
  logic              in_ready_nxt;
  logic              out_valid_nxt;

  assign accept = (state == IDLE) && bus.in_valid && bus.in_ready;

  // Datapath helpers: next binary bit, per-digit dabble correction and
  // the final Excess-3 bias (4-bit per digit, no inter-digit carry).
  always_comb begin
    bin_bit = prev_bit ^ gray_sr[BIN_W-1];
    bcd_adj = '0;
    ex3_nxt = '0;
    for (int d = 0; d < DIGITS; d++) begin
      bcd_adj[d*4 +: 4] = (bcd[d*4 +: 4] >= 4'd5) ? bcd[d*4 +: 4] + 4'd3
                                                   : bcd[d*4 +: 4];
      ex3_nxt[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)           state_nxt = CONV;
      CONV: if (count == '0)      state_nxt = ADJ;
      ADJ:                        state_nxt = DONE;
      DONE: if (bus.out_ready)    state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the upcoming state so in_ready
  // drops on the accept edge and rises on the release edge.
  always_comb begin
    busy          = (state == CONV) || (state == ADJ);
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.ex3       <= '0;
      bus.overflow  <= 1'b0;
      gray_sr       <= '0;
      prev_bit      <= 1'b0;
      count         <= '0;
      bcd           <= '0;
    end else begin
      bus.in_ready  <= in_ready_nxt;
      bus.out_valid <= out_valid_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            gray_sr      <= bus.gray;
            bcd          <= '0;
            prev_bit     <= 1'b0;
            bus.overflow <= 1'b0;
            count        <= CW'(BIN_W - 1);
          end
        end
        CONV: begin
          gray_sr      <= {gray_sr[BIN_W-2:0], 1'b0};
          bcd          <= {bcd_adj[BW-2:0], bin_bit};
          // Bit pushed out of the top digit means the value needs more digits.
          bus.overflow <= bus.overflow | bcd_adj[BW-1];
          prev_bit     <= bin_bit;
          count        <= count - 1'b1;
        end
        ADJ: begin
          bus.ex3 <= ex3_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gray_to_excess3_seq_ctrl.md
Name: gray_to_excess3_seq_ctrl

Overview:
Multi-cycle sequencer that converts a Gray-coded binary word to packed Excess-3 BCD. Each cycle it resolves one binary bit, MSB first, and feeds it into a shift-and-add-3 (double-dabble) BCD engine. It then applies a final +3 per digit. The block gives area-constrained paths the same result as the combinational Gray→BIN→BCD→EX3 chain, with valid/ready handshakes on both sides.

Parameters:
BIN_W, 16, width of the Gray input word (≥2)
DIGITS, 5, number of BCD/Excess-3 output digits (≥1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  gray word offered
in_ready  output  1  block can accept a word (registered)
gray  input  BIN_W  Gray-coded operand, sampled only on accept
out_valid  output  1  ex3/overflow hold a completed result
out_ready  input  1  consumer takes the result
ex3  output  DIGITS*4  packed Excess-3 result, digit 0 in bits [3:0]
overflow  output  1  value did not fit in DIGITS decimal digits
busy  output  1  state is CONV or ADJ

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high. All state updates on the rising clk edge.
- Reset values: state=IDLE, in_ready=0, out_valid=0, ex3=0, overflow=0, busy=0, internal gray/bin/bcd/bit-counter regs=0.
- in_ready goes to 1 at the first edge with rst low and stays 1 while the state is IDLE. It goes low at the accept edge.
- States: IDLE, CONV, ADJ, DONE.
- IDLE: an accept is in_valid&&in_ready at an edge. On accept:
  - latch gray into a shift register
  - clear bcd, prev_bit, overflow
  - set count=BIN_W-1
  - go to CONV.
  Changes on the gray input after the accept are ignored.
- CONV, one bit per cycle, MSB first:
  - b = prev_bit XOR g[count]
  - every BCD digit ≥5 gets +3
  - shift {bcd,b} left by 1
  - the bit leaving the top digit ORs into overflow
  - prev_bit=b
  - after count reaches 0, go to ADJ.
  CONV lasts exactly BIN_W cycles.
- ADJ: one cycle. Add 3 to every digit (4-bit, no inter-digit carry), register the result in ex3, set out_valid=1, go to DONE.
- Latency: out_valid is high starting BIN_W+1 cycles after the accept edge.
- DONE:
  - ex3 and overflow are held stable while out_valid=1 && !out_ready.
  - On an edge with out_ready=1: out_valid←0, state→IDLE, in_ready←1 on that same edge.
  - No same-cycle re-accept. Throughput is one word per BIN_W+3 cycles minimum.
- overflow is valid only with out_valid. When set, ex3 holds the low DIGITS digits of the true value, each still +3.
- busy=1 in CONV and ADJ only.
- rst asserted in any state, including mid-CONV or DONE: the result is discarded and all regs return to reset values at that edge. Nothing is emitted after reset.
- in_valid during CONV/ADJ/DONE is ignored (in_ready=0). The upstream side must hold it.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Reset then gray=16'h0000 accepted → after BIN_W+1 cycles out_valid=1, ex3=20'h33333, overflow=0. busy=1 for 17 cycles.
- gray=16'h0080 (bin 255) → ex3=20'h33588. gray=16'h2825 (bin 12345) → ex3=20'h45678. gray=16'h8000 (bin 65535) → ex3=20'h98868, overflow=0.
- BIN_W=8, DIGITS=2: gray=8'h52 (bin 99) → ex3=8'hCC, overflow=0. gray=8'h56 (bin 100) → ex3=8'h33, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → ex3/overflow stable, in_ready=0, new in_valid not accepted. Raise out_ready → in_ready=1 the next cycle, and the next word is accepted correctly.
- Change gray every cycle during CONV → result matches the value sampled at the accept edge.
- Assert rst for 1 cycle mid-CONV → out_valid stays 0, in_ready=1 one cycle after rst drops. The next conversion (gray=16'h0080) yields 20'h33588 with no residue.
